// File: rtl/acc_mem_pkg.sv
// Shared types and image geometry for the accelerator memory host.
// The result image sits directly above the input image in one word memory.
package acc_mem_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP, DONE} state_t;

    localparam int unsigned IMG_W     = 352;
    localparam int unsigned IMG_H     = 288;
    localparam int unsigned IMG_WORDS = IMG_W * IMG_H / 4;
    localparam int unsigned RES_BASE  = IMG_WORDS;
    localparam int unsigned DEPTH     = 2 * IMG_WORDS;
    localparam int unsigned ADDR_W    = 16;

endpackage

// File: rtl/acc_sp_ram.sv
// Single-port word RAM, synchronous read with one cycle of latency.
// Read data holds its last value whenever no read is issued.
module acc_sp_ram
    import acc_mem_pkg::*;
#(
    parameter int unsigned DEPTH = acc_mem_pkg::DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/acc_mem_host.sv
// Image memory owner and load/run/dump sequencer for the edge-detection accelerator.
// Optional out-of-range access flag built only with ACC_MEM_ADDR_CHECK_EN.
module acc_mem_host
    import acc_mem_pkg::*;
#(
    parameter int unsigned DEPTH     = acc_mem_pkg::DEPTH,
    parameter int unsigned IMG_WORDS = acc_mem_pkg::IMG_WORDS,
    parameter int unsigned RES_BASE  = acc_mem_pkg::RES_BASE,
    parameter int unsigned ADDR_W    = acc_mem_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic              acc_en,
    input  logic              acc_we,
    input  logic [31:0]       acc_dataW,
    output logic [31:0]       acc_dataR,
    output logic              acc_start,
    input  logic              acc_finish,
    output logic              busy,
    output logic              done,
    output logic [31:0]       cycle_cnt,
    output logic              err
);

    localparam int unsigned   AW         = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_WORD  = AW'(IMG_WORDS - 1);
    localparam logic [AW-1:0] RES_BASE_A = AW'(RES_BASE);

    state_t        state_q, state_d;
    logic [AW-1:0] word_cnt_q;
    logic          out_valid_q;
    logic          start_q;
    logic          acc_rd_q;
    logic          acc_rd_oor_q;
    logic [31:0]   acc_hold_q;
    logic [31:0]   acc_rd_data;
    logic [31:0]   cycle_cnt_q;

    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;

    logic          acc_in_range;
    logic          load_fire;
    logic          dump_fire;

    assign acc_in_range = (32'(acc_addr) < DEPTH);
    assign load_fire    = (state_q == LOAD) && in_valid;
    assign dump_fire    = (state_q == DUMP) && out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (go) state_d = LOAD;
            LOAD:       if (load_fire && word_cnt_q == LAST_WORD) state_d = RUN;
            RUN:        if (acc_finish) state_d = DUMP;
            DUMP:       if (dump_fire && word_cnt_q == LAST_WORD) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // The RAM port belongs to whoever owns the current phase.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            LOAD: begin
                ram_en    = in_valid;
                ram_we    = 1'b1;
                ram_addr  = word_cnt_q;
                ram_wdata = in_data;
            end
            RUN: begin
                ram_en    = acc_en && acc_in_range;
                ram_we    = acc_we;
                ram_addr  = AW'(acc_addr);
                ram_wdata = acc_dataW;
            end
            DUMP: begin
                ram_en    = !out_valid_q;
                ram_addr  = RES_BASE_A + word_cnt_q;
            end
            default: ;
        endcase
    end

    acc_sp_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Out-of-range reads never touch the RAM, so their result is forced to zero here.
    assign acc_rd_data = acc_rd_q ? (acc_rd_oor_q ? '0 : ram_rdata) : acc_hold_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            word_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            start_q      <= 1'b0;
            acc_rd_q     <= 1'b0;
            acc_rd_oor_q <= 1'b0;
            acc_hold_q   <= '0;
            cycle_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= (state_q == LOAD) && (state_d == RUN);
            acc_rd_q     <= (state_q == RUN) && acc_en && !acc_we;
            acc_rd_oor_q <= !acc_in_range;
            acc_hold_q   <= (state_q == RUN) ? acc_rd_data : '0;

            if ((state_q != LOAD && state_d == LOAD) || (state_q == RUN && state_d == DUMP)) begin
                word_cnt_q <= '0;
            end else if (load_fire || dump_fire) begin
                word_cnt_q <= word_cnt_q + 1'b1;
            end

            // One dump word in flight: read issued while invalid, valid the cycle after.
            if (state_q == DUMP) begin
                if (!out_valid_q) begin
                    out_valid_q <= 1'b1;
                end else if (out_ready) begin
                    out_valid_q <= 1'b0;
                end
            end else begin
                out_valid_q <= 1'b0;
            end

            // The finishing cycle itself is not counted as accelerator run time.
            if (state_q != RUN && state_d == RUN) begin
                cycle_cnt_q <= '0;
            end else if (state_q == RUN && !acc_finish && cycle_cnt_q != '1) begin
                cycle_cnt_q <= cycle_cnt_q + 1'b1;
            end
        end
    end

`ifdef ACC_MEM_ADDR_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state_q != LOAD && state_d == LOAD) begin
            err_q <= 1'b0;
        end else if (state_q == RUN && acc_en && !acc_in_range) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q == LOAD) || (state_q == RUN) || (state_q == DUMP);
    assign done      = (state_q == DONE);
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? ram_rdata : '0;
    assign acc_start = start_q;
    assign acc_dataR = (state_q == RUN) ? acc_rd_data : '0;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_acc_mem_host.sv
// Directed-random bench for acc_mem_host on a reduced image size.
// Memory contents are modelled as a plain array updated from the bus rules.
module tb_acc_mem_host;

    localparam int DEPTH     = 256;
    localparam int IMG_WORDS = 128;
    localparam int RES_BASE  = 128;
    localparam int ADDR_W    = 16;
`ifdef ACC_MEM_ADDR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              go;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_en;
    logic              acc_we;
    logic [31:0]       acc_dataW;
    logic [31:0]       acc_dataR;
    logic              acc_start;
    logic              acc_finish;
    logic              busy;
    logic              done;
    logic [31:0]       cycle_cnt;
    logic              err;

    int          checks = 0;
    int          errors = 0;
    int          run_cyc = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] last_rd;

    acc_mem_host #(
        .DEPTH     (DEPTH),
        .IMG_WORDS (IMG_WORDS),
        .RES_BASE  (RES_BASE),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .acc_addr   (acc_addr),
        .acc_en     (acc_en),
        .acc_we     (acc_we),
        .acc_dataW  (acc_dataW),
        .acc_dataR  (acc_dataR),
        .acc_start  (acc_start),
        .acc_finish (acc_finish),
        .busy       (busy),
        .done       (done),
        .cycle_cnt  (cycle_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        run_cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_go();
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("go_busy", busy, 1);
        chk("go_in_ready", in_ready, 1);
        chk("load_err_clear", err, 0);
    endtask

    task automatic do_load(input int n, input bit rnd);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = rnd ? 32'($urandom) : 32'(i);
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            in_valid = 1'b1;
            in_data  = w;
            go       = (i == 10);
            if (i == 0 || i == n - 1) chk("load_ready", in_ready, 1);
            tick();
            model_mem[i] = w;
        end
        in_valid = 1'b0;
        go       = 1'b0;
    endtask

    task automatic acc_read(input int addr);
        logic [31:0] exp;
        acc_en   = 1'b1;
        acc_we   = 1'b0;
        acc_addr = 16'(addr);
        tick();
        acc_en  = 1'b0;
        exp     = (addr < DEPTH) ? model_mem[addr] : 32'h0;
        last_rd = exp;
        chk("acc_read", acc_dataR, exp);
    endtask

    task automatic acc_write(input int addr, input logic [31:0] d);
        acc_en    = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = 16'(addr);
        acc_dataW = d;
        tick();
        acc_en = 1'b0;
        acc_we = 1'b0;
        if (addr < DEPTH) model_mem[addr] = d;
        chk("acc_hold_on_write", acc_dataR, last_rd);
    endtask

    task automatic run_phase(input int n_fin, input bit rnd_res, input bit err_test, input bit prev_res);
        run_cyc = 0;
        chk("run_in_ready", in_ready, 0);
        chk("start_pulse", acc_start, 1);
        chk("cyc_clear", cycle_cnt, 0);
        tick();
        chk("start_once", acc_start, 0);
        acc_read(5);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("read_hold", acc_dataR, model_mem[5]);
        end
        if (prev_res) acc_read(RES_BASE);
        acc_read(0);
        repeat (6) acc_read(int'($urandom_range(0, IMG_WORDS - 1)));
        acc_read(DEPTH + int'($urandom_range(0, 1000)));
        for (int k = 0; k < IMG_WORDS; k++) begin
            acc_write(RES_BASE + k, rnd_res ? 32'($urandom) : ~32'(k));
            if (k % 32 == 7) acc_read(RES_BASE + k);
        end
        if (err_test) begin
            acc_write(DEPTH, 32'hBAD0_BAD0);
            chk("err_set", err, ERR_EN);
            acc_write(DEPTH + 5, 32'h5A5A_5A5A);
            acc_read(5);
            acc_read(RES_BASE);
            chk("err_sticky", err, ERR_EN);
        end else begin
            chk("err_low", err, 0);
        end
        chk("cyc_run", cycle_cnt, run_cyc);
        for (int b = 0; b < 5000 && run_cyc < n_fin; b++) tick();
        acc_finish = 1'b1;
        tick();
        acc_finish = 1'b0;
        chk("cyc_dump", cycle_cnt, n_fin);
        chk("dump_dataR_zero", acc_dataR, 0);
        chk("dump_busy", busy, 1);
    endtask

    task automatic dump_phase(input int n_fin);
        int b;
        for (int k = 0; k < IMG_WORDS; k++) begin
            b = 0;
            while (!out_valid && b < 8) begin
                tick();
                b++;
            end
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, model_mem[RES_BASE + k]);
            if (k == 3) begin
                repeat (10) begin
                    tick();
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, model_mem[RES_BASE + 3]);
                end
            end
            repeat ($urandom_range(0, 2)) tick();
            out_ready = 1'b1;
            go        = (k == 5);
            tick();
            out_ready = 1'b0;
            go        = 1'b0;
            chk("one_in_flight", out_valid, 0);
        end
        chk("done", done, 1);
        chk("done_busy", busy, 0);
        chk("done_cyc", cycle_cnt, n_fin);
    endtask

    initial begin
        int n_fin;
        reset      = 1'b1;
        go         = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        acc_addr   = '0;
        acc_en     = 1'b0;
        acc_we     = 1'b0;
        acc_dataW  = '0;
        acc_finish = 1'b0;
        last_rd    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_acc_start", acc_start, 0);
        chk("rst_acc_dataR", acc_dataR, 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        go    = 1'b0;
        tick();
        chk("idle_after_reset", busy, 0);

        // Sequence A: index pattern in, inverted index results out, 1000-cycle run.
        start_go();
        do_load(IMG_WORDS, 1'b0);
        run_phase(1000, 1'b0, 1'b0, 1'b0);
        dump_phase(1000);
        repeat (2) tick();
        chk("done_level", done, 1);
        acc_en    = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = 16'(RES_BASE);
        acc_dataW = 32'hDEAD_BEEF;
        tick();
        acc_en = 1'b0;
        acc_we = 1'b0;
        chk("done_dataR_zero", acc_dataR, 0);

        // Sequence B: random data, out-of-range accesses.
        start_go();
        do_load(IMG_WORDS, 1'b1);
        n_fin = 300 + int'($urandom_range(0, 50));
        run_phase(n_fin, 1'b1, 1'b1, 1'b1);
        dump_phase(n_fin);

        // Sequence C: reset during load, then a clean restart.
        start_go();
        do_load(101, 1'b1);
        reset = 1'b1;
        go    = 1'b1;
        #2;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_cycle_cnt", cycle_cnt, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_done", done, 0);
        tick();
        reset = 1'b0;
        go    = 1'b0;
        tick();
        chk("idle_after_mid_rst", busy, 0);
        start_go();
        do_load(IMG_WORDS, 1'b1);
        n_fin = 260 + int'($urandom_range(0, 40));
        run_phase(n_fin, 1'b1, 1'b0, 1'b1);
        dump_phase(n_fin);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
